// File: rtl/audio_envelope.sv
// ADSR envelope shaper for the 1-bit tone stream.
// PWM-gates tone_in by the current envelope level.
module audio_envelope #(
  parameter int TICK_DIV      = 4096,
  parameter int ATTACK_STEP   = 8,
  parameter int DECAY_STEP    = 4,
  parameter int SUSTAIN_LEVEL = 160,
  parameter int RELEASE_STEP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tone_in,
  input  logic       gate,
  output logic       audio_out,
  output logic [7:0] env_level,
  output logic [2:0] env_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  localparam logic [8:0] A9   = 9'(ATTACK_STEP);
  localparam logic [8:0] D9   = 9'(DECAY_STEP);
  localparam logic [8:0] S9   = 9'(SUSTAIN_LEVEL);
  localparam logic [8:0] R9   = 9'(RELEASE_STEP);
  localparam logic [8:0] MAX9 = 9'd255;

  env_t          state;
  logic [PW-1:0] pre;
  logic          tick;
  logic [7:0]    pwm_cnt;
  logic [8:0]    lvl9;
  logic [8:0]    att_sum;
  logic [8:0]    dec_diff;

  assign tick      = (pre == PMAX);
  assign lvl9      = {1'b0, env_level};
  assign att_sum   = lvl9 + A9;
  assign dec_diff  = lvl9 - D9;
  assign env_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt   <= 8'd0;
      audio_out <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 8'd1;
      audio_out <= tone_in & (pwm_cnt < env_level);
    end
  end

  // Gate edges win over a coincident tick: state moves, level holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      env_level <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gate) state <= ATTACK;
        end
        ATTACK: begin
          if (!gate) begin
            state <= RELEASE;
          end else if (tick) begin
            if (att_sum >= MAX9) begin
              env_level <= 8'hff;
              state     <= DECAY;
            end else begin
              env_level <= att_sum[7:0];
            end
          end
        end
        DECAY: begin
          if (!gate) begin
            state <= RELEASE;
          end else if (tick) begin
            if ($signed(dec_diff) <= $signed(S9)) begin
              env_level <= S9[7:0];
              state     <= SUSTAIN;
            end else begin
              env_level <= dec_diff[7:0];
            end
          end
        end
        SUSTAIN: begin
          if (!gate) state <= RELEASE;
        end
        RELEASE: begin
          if (gate) begin
            state <= ATTACK;
          end else if (tick) begin
            if (lvl9 <= R9) begin
              env_level <= 8'd0;
              state     <= IDLE;
            end else begin
              env_level <= env_level - R9[7:0];
            end
          end
        end
        default: begin
          state     <= IDLE;
          env_level <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_envelope.sv
// Bench for audio_envelope: cycle model compare plus
// directed ADSR, PWM duty and saturation checks.
module tb_audio_envelope;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tone_a, gate_a, tone_b, gate_b;
  logic       a_aout, b_aout;
  logic [7:0] a_level, b_level;
  logic [2:0] a_state, b_state;

  always #5 clk = ~clk;

  audio_envelope #(
    .TICK_DIV(TD), .ATTACK_STEP(64), .DECAY_STEP(32),
    .SUSTAIN_LEVEL(128), .RELEASE_STEP(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_a), .gate(gate_a),
    .audio_out(a_aout), .env_level(a_level), .env_state(a_state)
  );

  audio_envelope #(
    .TICK_DIV(TD), .ATTACK_STEP(255), .DECAY_STEP(32),
    .SUSTAIN_LEVEL(255), .RELEASE_STEP(255)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_b), .gate(gate_b),
    .audio_out(b_aout), .env_level(b_level), .env_state(b_state)
  );

  typedef struct {
    int level;
    int st;
    int pre;
    int pwm;
    bit aout;
  } m_t;

  m_t ma, mb;
  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  function automatic m_t step(m_t m, bit g, bit tn,
                              int as, int ds, int sl, int rs);
    m_t n = m;
    bit tk = (m.pre == TD - 1);
    n.pre  = (m.pre + 1) % TD;
    n.pwm  = (m.pwm + 1) % 256;
    n.aout = tn && (m.pwm < m.level);
    case (m.st)
      0: if (g) n.st = 1;
      1: begin
        if (!g) n.st = 4;
        else if (tk) begin
          n.level = (m.level + as > 255) ? 255 : m.level + as;
          if (n.level == 255) n.st = 2;
        end
      end
      2: begin
        if (!g) n.st = 4;
        else if (tk) begin
          if (m.level - ds <= sl) begin
            n.level = sl;
            n.st = 3;
          end else n.level = m.level - ds;
        end
      end
      3: if (!g) n.st = 4;
      4: begin
        if (g) n.st = 1;
        else if (tk) begin
          if (m.level <= rs) begin
            n.level = 0;
            n.st = 0;
          end else n.level = m.level - rs;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= step(ma, gate_a, tone_a, 64, 32, 128, 16);
      mb <= step(mb, gate_b, tone_b, 255, 32, 255, 255);
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_a_level", int'(a_level), ma.level);
      chk("model_a_state", int'(a_state), ma.st);
      chk("model_a_audio", int'(a_aout), int'(ma.aout));
      chk("model_b_level", int'(b_level), mb.level);
      chk("model_b_state", int'(b_state), mb.st);
      chk("model_b_audio", int'(b_aout), int'(mb.aout));
    end
  end

  task automatic wait_chg(bit b);
    logic [7:0] l0;
    logic [2:0] s0;
    bit ok;
    l0 = b ? b_level : a_level;
    s0 = b ? b_state : a_state;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if ((b ? b_level : a_level) != l0 ||
          (b ? b_state : a_state) != s0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_chg: no change within 64 cycles");
    end
  endtask

  task automatic wait_state(int s, int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (int'(a_state) == s) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_state: state %0d not reached", s);
    end
  endtask

  task automatic duty(bit b, string nm, int exp);
    int cnt;
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      cnt += b ? int'(b_aout) : int'(a_aout);
    end
    chk(nm, cnt, exp);
  endtask

  initial begin
    int bad;
    bit hit;
    rst_n  = 1'b0;
    gate_a = 1'b0;
    gate_b = 1'b0;
    tone_a = 1'b1;
    tone_b = 1'b1;
    #1;
    started = 1'b1;
    chk("rst_level", int'(a_level), 0);
    chk("rst_state", int'(a_state), 0);
    chk("rst_audio", int'(a_aout), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_level", int'(a_level), 0);
    chk("idle_state", int'(a_state), 0);

    // full ADSR
    gate_a = 1'b1;
    @(negedge clk);
    chk("adsr_attack", int'(a_state), 1);
    wait_chg(0); chk("att_64", int'(a_level), 64);
    wait_chg(0); chk("att_128", int'(a_level), 128);
    wait_chg(0); chk("att_192", int'(a_level), 192);
    wait_chg(0); chk("att_255", int'(a_level), 255);
    chk("att_to_decay", int'(a_state), 2);
    wait_chg(0); chk("dec_223", int'(a_level), 223);
    wait_chg(0); chk("dec_191", int'(a_level), 191);
    wait_chg(0); chk("dec_159", int'(a_level), 159);
    wait_chg(0); chk("dec_128", int'(a_level), 128);
    chk("dec_to_sus", int'(a_state), 3);
    repeat (100) @(negedge clk);
    chk("sus_hold", int'(a_level), 128);
    duty(0, "duty_128", 128);
    tone_a = 1'b0;
    @(negedge clk);
    chk("lat_tone_off", int'(a_aout), 0);
    duty(0, "duty_tone0", 0);
    tone_a = 1'b1;
    gate_a = 1'b0;
    @(negedge clk);
    chk("rel_enter", int'(a_state), 4);
    chk("rel_nojump", int'(a_level), 128);
    for (int k = 1; k <= 8; k++) begin
      wait_chg(0);
      chk("rel_step", int'(a_level), 128 - 16 * k);
    end
    chk("rel_idle", int'(a_state), 0);

    // early release and retrigger
    gate_a = 1'b1;
    @(negedge clk);
    chk("er_attack", int'(a_state), 1);
    wait_chg(0); chk("er_64", int'(a_level), 64);
    wait_chg(0); chk("er_128", int'(a_level), 128);
    gate_a = 1'b0;
    @(negedge clk);
    chk("er_rel", int'(a_state), 4);
    chk("er_nojump", int'(a_level), 128);
    wait_chg(0); chk("er_112", int'(a_level), 112);
    wait_chg(0); chk("er_96", int'(a_level), 96);
    gate_a = 1'b1;
    @(negedge clk);
    chk("rt_attack", int'(a_state), 1);
    chk("rt_keep", int'(a_level), 96);
    wait_chg(0); chk("rt_160", int'(a_level), 160);
    wait_chg(0); chk("rt_224", int'(a_level), 224);
    wait_chg(0); chk("rt_255", int'(a_level), 255);
    chk("rt_decay", int'(a_state), 2);

    // gate drop on a tick edge during ATTACK
    gate_a = 1'b0;
    wait_state(0, 200);
    gate_a = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (a_state == 3'd1 && a_level != 8'd0 && ma.pre == TD - 1)
        hit = 1'b1;
    end
    chk("coll_found", int'(hit), 1);
    gate_a = 1'b0;
    @(negedge clk);
    chk("coll_state", int'(a_state), 4);
    chk("coll_level", int'(a_level), 64);

    // saturation edges on the second instance
    gate_b = 1'b1;
    @(negedge clk);
    chk("b_attack", int'(b_state), 1);
    wait_chg(1);
    chk("b_att_255", int'(b_level), 255);
    chk("b_decay", int'(b_state), 2);
    wait_chg(1);
    chk("b_sus_255", int'(b_level), 255);
    chk("b_sustain", int'(b_state), 3);
    duty(1, "duty_255", 255);
    gate_b = 1'b0;
    @(negedge clk);
    chk("b_rel", int'(b_state), 4);
    wait_chg(1);
    chk("b_rel_0", int'(b_level), 0);
    chk("b_idle", int'(b_state), 0);

    // randomized gate/tone traffic
    repeat (3000) begin
      @(negedge clk);
      tone_a = 1'($urandom);
      tone_b = 1'($urandom);
      if ($urandom_range(0, 15) == 0) gate_a = ~gate_a;
      if ($urandom_range(0, 15) == 0) gate_b = ~gate_b;
    end

    // asynchronous reset in SUSTAIN
    tone_a = 1'b1;
    gate_a = 1'b1;
    wait_state(3, 500);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", int'(a_level), 0);
    chk("mid_rst_state", int'(a_state), 0);
    chk("mid_rst_audio", int'(a_aout), 0);
    gate_a = 1'b0;
    gate_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (a_state != 3'd0 || a_level != 8'd0 || a_aout != 1'b0) bad++;
    end
    chk("idle_after_rst", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_envelope.md
Name: audio_envelope

Overview:
- Downstream stage of the square-wave tone generator: amplitude-shapes its 1-bit `audio_out` stream with an ADSR envelope.
- Output is PWM-gated: tone AND (pwm_cnt < env_level).
- Sits between the tone generator and the top-level audio pin.
- `gate` comes from the demo control logic (note on/off).

Parameters:
- TICK_DIV, 4096: clock cycles per envelope tick (≥2).
- ATTACK_STEP, 8: level increment per tick in ATTACK (1..255).
- DECAY_STEP, 4: level decrement per tick in DECAY (1..255).
- SUSTAIN_LEVEL, 160: level held in SUSTAIN (0..255).
- RELEASE_STEP, 2: level decrement per tick in RELEASE (1..255).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- tone_in, input, 1: square-wave tone from the upstream generator; synchronous to clk.
- gate, input, 1: note on (1) / off (0); synchronous, level-sensitive.
- audio_out, output, 1: envelope-modulated audio bit.
- env_level, output, 8: current envelope amplitude.
- env_state, output, 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Behaviour:
- Reset (rst_n low, async):
  - audio_out=0, env_level=0, env_state=IDLE.
  - Prescaler=0, pwm_cnt=0.
  - Mid-note reset aborts immediately; no release phase.
- Prescaler:
  - Free-runs 0..TICK_DIV-1, wraps to 0.
  - tick=1 for the one cycle where count==TICK_DIV-1; first tick is at cycle TICK_DIV-1 after reset release.
- Level arithmetic:
  - Done 9 bits wide; env_level never wraps.
  - env_level changes only on tick cycles; state changes may occur on any cycle.
- IDLE: gate=1 -> ATTACK on the next clk. Level stays 0.
- ATTACK, on tick: level = min(255, level+ATTACK_STEP). If the result is 255 -> DECAY.
- DECAY, on tick:
  - If level-DECAY_STEP ≤ SUSTAIN_LEVEL (signed 9-bit compare): level=SUSTAIN_LEVEL, go to SUSTAIN.
  - Otherwise subtract DECAY_STEP.
  - With SUSTAIN_LEVEL=255, the first decay tick goes straight to SUSTAIN at 255.
- SUSTAIN: level held at SUSTAIN_LEVEL.
- gate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE on the next clk.
  - This has priority over a coincident tick: no level update that cycle.
- RELEASE:
  - On tick: if level ≤ RELEASE_STEP, level=0 and go to IDLE; else subtract RELEASE_STEP.
  - gate=1 in RELEASE -> ATTACK next clk; ramp continues from the current level (retrigger, no click to 0).
- Gate toggling between ticks: only the state follows; level is untouched until the next tick.
- PWM:
  - 8-bit pwm_cnt increments every clk, wraps 255->0.
  - pwm_on = (pwm_cnt < env_level).
  - level 0: always off. level 255: on 255 of 256 cycles.
- Output:
  - audio_out registered: audio_out <= tone_in & pwm_on.
  - Latency is 1 clk from tone_in/pwm_cnt to audio_out.
- Outputs env_level and env_state are registers, no combinational paths to ports.

Test Plan (TICK_DIV=4, ATTACK_STEP=64, DECAY_STEP=32, SUSTAIN_LEVEL=128, RELEASE_STEP=16, tone_in=1):
- Reset checks:
  - Assert rst_n=0 mid-SUSTAIN -> env_level=0, env_state=0, audio_out=0 immediately, without waiting for a clk edge.
  - After release with gate=0, outputs stay idle for 1000 cycles.
- Full ADSR:
  - gate=1 -> state 1.
  - Level sequence 64, 128, 192, 255 on successive ticks, then state 2.
  - Decay 223, 191, 159, then 128 with state 3.
  - Hold 128 for 100 cycles.
  - gate=0 -> state 4, level falls by 16 per tick; after 8 ticks level=0, state 0.
- Early release and retrigger:
  - gate=0 after level=128 in ATTACK -> RELEASE with no level jump.
  - Re-assert gate at level=96 -> ATTACK resumes 160, 224, 255.
- Tick collision: drop gate on exactly a tick cycle in ATTACK -> state 4 next clk, level unchanged that cycle.
- PWM duty:
  - In SUSTAIN at 128, count audio_out highs over 256 cycles -> exactly 128.
  - tone_in=0 -> 0.
  - At level 255 -> 255 highs.
  - Check the 1-cycle tone_in->audio_out latency.
- Saturation edges:
  - ATTACK_STEP=255 -> 255 on the first tick.
  - SUSTAIN_LEVEL=255 -> DECAY exits on its first tick at 255.
  - RELEASE_STEP=255 -> reaches 0 and IDLE in one tick.
